wm8731_audio_bus_responder: RTL and testbench
=============================================

# wm8731_audio_bus_responder

Synthesizable model of the WM8731 end of the digital audio bus, in slave mode. It oversamples the bit clock and LR clocks driven by the FPGA-side codec transceiver on the system clock. It deserializes AUD_DACDAT into left and right DAC samples and serializes supplied left and right ADC samples onto AUD_ADCDAT. It serves as the codec stand-in for loopback self-test and simulation of the audio path, and as a bus monitor.

## Interface
- SAMPLE_BITS, 16, bits per channel sample
- SYNC_STAGES, 2, synchronizer flops on each bus input (minimum 2)

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET_N  in  1  asynchronous active-low reset
- AUD_BCLK  in  1  bit clock from the transceiver
- AUD_DACLRCK  in  1  DAC LR clock: low = left, high = right
- AUD_DACDAT  in  1  serial DAC data
- AUD_ADCLRCK  in  1  ADC LR clock: low = left, high = right
- AUD_ADCDAT  out  1  serial ADC data
- DAC_LCHAN_DATA  out  SAMPLE_BITS  last complete left sample received
- DAC_RCHAN_DATA  out  SAMPLE_BITS  last complete right sample received
- DAC_LCHAN_VALID  out  1  one-CLK pulse when DAC_LCHAN_DATA updates
- DAC_RCHAN_VALID  out  1  one-CLK pulse when DAC_RCHAN_DATA updates
- ADC_LCHAN_DATA  in  SAMPLE_BITS  left sample to transmit
- ADC_RCHAN_DATA  in  SAMPLE_BITS  right sample to transmit
- ADC_LCHAN_TRIG  out  1  one-CLK pulse when ADC_LCHAN_DATA is captured
- ADC_RCHAN_TRIG  out  1  one-CLK pulse when ADC_RCHAN_DATA is captured
- FRAME_ERR  out  1  one-CLK pulse when a DAC slot is too short

## Operation
- Bus format is I2S.
  - The MSB is sampled on the 2nd BCLK rising edge after an LRCK transition.
  - The bit count per slot is at least SAMPLE_BITS+1 BCLKs. Bits beyond SAMPLE_BITS are ignored on receive and driven 0 on transmit.
- All bus inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronized value with the previous one.
- DAC receive FSM states:
  - WAIT_EDGE → on a DACLRCK edge, latch channel = new DACLRCK value, clear bit counter → SKIP.
  - SKIP → on BCLK rise → SHIFT.
  - SHIFT → on each BCLK rise, shift DACDAT in MSB-first and increment the counter. At count = SAMPLE_BITS, update the selected channel's data register, pulse its VALID, and go to WAIT_EDGE.
  - In SKIP or SHIFT, a DACLRCK edge pulses FRAME_ERR, discards the partial word, and restarts SKIP for the new channel.
- The first DACLRCK edge after reset establishes alignment. Any partial slot before that edge is ignored without FRAME_ERR.
- ADC transmit:
  - On an ADCLRCK edge, load the selected channel's input into the transmit shift register and pulse the matching TRIG. The mapping is low → ADC_LCHAN_DATA/ADC_LCHAN_TRIG, high → ADC_RCHAN_DATA/ADC_RCHAN_TRIG.
  - Drive the MSB on the 1st BCLK falling edge after the ADCLRCK edge, then shift left on each following fall. After SAMPLE_BITS bits, drive 0 until the next ADCLRCK edge.
  - A new ADCLRCK edge always reloads, even when the previous slot is incomplete. This does not raise an error.
- DAC and ADC paths are independent. DACLRCK and ADCLRCK may be the same signal or different signals.

## Timing
- Reset values:
  - AUD_ADCDAT, all VALID, TRIG and FRAME_ERR pulses = 0.
  - DAC data outputs = 0.
  - Shift registers, counters = 0.
  - Both FSMs are in WAIT_EDGE.
  - The alignment flag is clear.
- Reset mid-slot discards everything. Outputs return to reset values asynchronously.
- Oversampling: each BCLK high and low phase lasts at least SYNC_STAGES+2 CLK cycles. At 50 MHz with BCLK ≤ 3.125 MHz this holds.
- VALID latency: VALID asserts SYNC_STAGES+1 CLK after the BCLK rising edge that carries the LSB. DAC data becomes stable on that same cycle and holds until the next update.
- TRIG latency: TRIG asserts SYNC_STAGES+1 CLK after the ADCLRCK edge at the pin. ADC inputs are sampled on that same cycle only.
- ADCDAT output: updates SYNC_STAGES+1 CLK after the BCLK fall at the pin. Setup to the next BCLK rise is at least one half-period minus this delay.
- Simultaneous events: an LRCK edge and a BCLK rise on the same CLK cycle are handled as the LRCK edge first. That BCLK rise counts as the skipped bit.

## Structure
- A shared package `wm8731_bus_pkg` holds the FSM state enum (WAIT_EDGE, SKIP, SHIFT) and the LRCK channel constants (LEFT=0, RIGHT=1).
- One sub-module, `wm8731_bus_sync_edge`: a SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated once each for BCLK, DACLRCK and ADCLRCK, plus a synchronizer only for DACDAT.
- The receive FSM and the transmit shifter stay in the top module.

## Test plan
- Reset, then an I2S frame carrying L=16'hA55A, R=16'h1234 at BCLK = 3.072 MHz, LRCK = 48 kHz, 32 BCLK/slot → one DAC_LCHAN_VALID with 16'hA55A, then one DAC_RCHAN_VALID with 16'h1234. No FRAME_ERR.
- ADC_LCHAN_DATA=16'h8001, ADC_RCHAN_DATA=16'h7FFE with ADCLRCK tied to DACLRCK → the serial capture of AUD_ADCDAT on BCLK rises equals 8001/7FFE. Each TRIG pulses once per slot, and trailing bits are 0.
- DACLRCK toggles after only 10 bits of a left slot → FRAME_ERR pulses once, DAC_LCHAN_DATA is unchanged, and the following right slot (16'hBEEF) is received correctly.
- Minimum slot of exactly 17 BCLK, data 16'hFFFF/16'h0000 → both words received with no error.
- RESET_N asserted mid-shift of a right slot → the outputs clear immediately. After release, the first complete frame (16'h0F0F/16'hF0F0) is received correctly, with no VALID for the truncated slot.
- Power-up with BCLK running and LRCK mid-slot → no VALID and no FRAME_ERR until after the first LRCK edge.

Source files
------------

// File: rtl/wm8731_bus_pkg.sv
// Shared definitions for the WM8731 slave-mode bus responder: FSM states and
// LR clock channel encodings.
package wm8731_bus_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    SKIP      = 2'd1,
    SHIFT     = 2'd2
  } bus_state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/wm8731_bus_sync_edge.sv
// Multi-stage synchronizer for one audio bus line with single-cycle rise/fall pulses.
// Edges are suppressed until the chain holds real samples, so a line already high at reset release is not an edge.
module wm8731_bus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic [SYNC_STAGES:0]   fill;
  logic                   primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      fill  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign primed   = fill[SYNC_STAGES];
  assign rise     = primed & sync_out & ~prev;
  assign fall     = primed & ~sync_out & prev;

endmodule

// File: rtl/wm8731_audio_bus_responder.sv
// WM8731 codec stand-in on the I2S bus in slave mode: deserializes DAC data and
// serializes ADC samples, all timed from oversampled BCLK/LRCK edges.
module wm8731_audio_bus_responder
  import wm8731_bus_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   AUD_BCLK,
  input  logic                   AUD_DACLRCK,
  input  logic                   AUD_DACDAT,
  input  logic                   AUD_ADCLRCK,
  output logic                   AUD_ADCDAT,
  output logic [SAMPLE_BITS-1:0] DAC_LCHAN_DATA,
  output logic [SAMPLE_BITS-1:0] DAC_RCHAN_DATA,
  output logic                   DAC_LCHAN_VALID,
  output logic                   DAC_RCHAN_VALID,
  input  logic [SAMPLE_BITS-1:0] ADC_LCHAN_DATA,
  input  logic [SAMPLE_BITS-1:0] ADC_RCHAN_DATA,
  output logic                   ADC_LCHAN_TRIG,
  output logic                   ADC_RCHAN_TRIG,
  output logic                   FRAME_ERR
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

  logic bclk_level_unused, bclk_rise, bclk_fall;
  logic daclrc_level, daclrc_rise, daclrc_fall;
  logic adclrc_level, adclrc_rise, adclrc_fall;
  logic dacdat_sync, dacdat_rise_unused, dacdat_fall_unused;
  logic dac_lr_edge, adc_lr_edge;

  wm8731_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(CLK), .rst_n(RESET_N), .din(AUD_BCLK),
    .sync_out(bclk_level_unused), .rise(bclk_rise), .fall(bclk_fall)
  );
  wm8731_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_daclrc (
    .clk(CLK), .rst_n(RESET_N), .din(AUD_DACLRCK),
    .sync_out(daclrc_level), .rise(daclrc_rise), .fall(daclrc_fall)
  );
  wm8731_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adclrc (
    .clk(CLK), .rst_n(RESET_N), .din(AUD_ADCLRCK),
    .sync_out(adclrc_level), .rise(adclrc_rise), .fall(adclrc_fall)
  );
  wm8731_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dacdat (
    .clk(CLK), .rst_n(RESET_N), .din(AUD_DACDAT),
    .sync_out(dacdat_sync), .rise(dacdat_rise_unused), .fall(dacdat_fall_unused)
  );

  assign dac_lr_edge = daclrc_rise | daclrc_fall;
  assign adc_lr_edge = adclrc_rise | adclrc_fall;

  bus_state_t             rx_state, rx_state_nxt, tx_state, tx_state_nxt;
  logic [SAMPLE_BITS-1:0] rx_shift, rx_word_next, tx_shift;
  logic [CNT_W-1:0]       rx_count, tx_count;
  logic                   rx_chan, aligned;
  logic                   rx_restart, rx_shift_en, rx_commit, frame_err_nxt;
  logic                   tx_load, tx_shift_en, tx_pad;

  assign rx_word_next = {rx_shift[SAMPLE_BITS-2:0], dacdat_sync};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state <= WAIT_EDGE;
      tx_state <= WAIT_EDGE;
    end else begin
      rx_state <= rx_state_nxt;
      tx_state <= tx_state_nxt;
    end
  end

  // An LRCK edge wins over a coincident BCLK rise, and that rise is the skipped bit.
  always_comb begin
    rx_state_nxt  = rx_state;
    rx_restart    = 1'b0;
    rx_shift_en   = 1'b0;
    rx_commit     = 1'b0;
    frame_err_nxt = 1'b0;
    if (dac_lr_edge) begin
      rx_restart    = 1'b1;
      frame_err_nxt = aligned && (rx_state != WAIT_EDGE);
      rx_state_nxt  = bclk_rise ? SHIFT : SKIP;
    end else begin
      case (rx_state)
        SKIP: if (bclk_rise) rx_state_nxt = SHIFT;
        SHIFT: if (bclk_rise) begin
          rx_shift_en = 1'b1;
          if (rx_count == CNT_W'(SAMPLE_BITS - 1)) begin
            rx_commit    = 1'b1;
            rx_state_nxt = WAIT_EDGE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_shift        <= '0;
      rx_count        <= '0;
      rx_chan         <= LEFT;
      aligned         <= 1'b0;
      DAC_LCHAN_DATA  <= '0;
      DAC_RCHAN_DATA  <= '0;
      DAC_LCHAN_VALID <= 1'b0;
      DAC_RCHAN_VALID <= 1'b0;
      FRAME_ERR       <= 1'b0;
    end else begin
      DAC_LCHAN_VALID <= rx_commit && (rx_chan == LEFT);
      DAC_RCHAN_VALID <= rx_commit && (rx_chan == RIGHT);
      FRAME_ERR       <= frame_err_nxt;
      if (rx_restart) begin
        rx_chan  <= daclrc_level;
        rx_count <= '0;
        rx_shift <= '0;
        aligned  <= 1'b1;
      end else if (rx_shift_en) begin
        rx_shift <= rx_word_next;
        rx_count <= rx_count + CNT_W'(1);
      end
      if (rx_commit) begin
        if (rx_chan == LEFT) DAC_LCHAN_DATA <= rx_word_next;
        else                 DAC_RCHAN_DATA <= rx_word_next;
      end
    end
  end

  // A fall coincident with the ADCLRCK edge is not the first fall of the new slot.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_shift_en  = 1'b0;
    tx_pad       = 1'b0;
    if (adc_lr_edge) begin
      tx_load      = 1'b1;
      tx_state_nxt = SHIFT;
    end else if (bclk_fall) begin
      case (tx_state)
        SHIFT: begin
          tx_shift_en = 1'b1;
          if (tx_count == CNT_W'(SAMPLE_BITS - 1)) tx_state_nxt = WAIT_EDGE;
        end
        default: tx_pad = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_shift       <= '0;
      tx_count       <= '0;
      AUD_ADCDAT     <= 1'b0;
      ADC_LCHAN_TRIG <= 1'b0;
      ADC_RCHAN_TRIG <= 1'b0;
    end else begin
      ADC_LCHAN_TRIG <= tx_load && (adclrc_level == LEFT);
      ADC_RCHAN_TRIG <= tx_load && (adclrc_level == RIGHT);
      if (tx_load) begin
        tx_shift <= (adclrc_level == LEFT) ? ADC_LCHAN_DATA : ADC_RCHAN_DATA;
        tx_count <= '0;
      end else if (tx_shift_en) begin
        AUD_ADCDAT <= tx_shift[SAMPLE_BITS-1];
        tx_shift   <= {tx_shift[SAMPLE_BITS-2:0], 1'b0};
        tx_count   <= tx_count + CNT_W'(1);
      end else if (tx_pad) begin
        AUD_ADCDAT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wm8731_audio_bus_responder.sv
// Bench acting as the I2S master: drives slots, predicts pulses/data from slot
// rules (skip bit, 16 data bits, minimum 17 BCLKs) and checks every cycle.
module tb_wm8731_audio_bus_responder;

  localparam int SB   = 16;
  localparam int SS   = 2;
  localparam int HALF = 8;
  localparam int LAT  = SS + 1;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_ADCLRCK, AUD_ADCDAT;
  logic [SB-1:0] DAC_LCHAN_DATA, DAC_RCHAN_DATA, ADC_LCHAN_DATA, ADC_RCHAN_DATA;
  logic          DAC_LCHAN_VALID, DAC_RCHAN_VALID, ADC_LCHAN_TRIG, ADC_RCHAN_TRIG, FRAME_ERR;

  wm8731_audio_bus_responder #(.SAMPLE_BITS(SB), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
    .DAC_LCHAN_DATA(DAC_LCHAN_DATA), .DAC_RCHAN_DATA(DAC_RCHAN_DATA),
    .DAC_LCHAN_VALID(DAC_LCHAN_VALID), .DAC_RCHAN_VALID(DAC_RCHAN_VALID),
    .ADC_LCHAN_DATA(ADC_LCHAN_DATA), .ADC_RCHAN_DATA(ADC_RCHAN_DATA),
    .ADC_LCHAN_TRIG(ADC_LCHAN_TRIG), .ADC_RCHAN_TRIG(ADC_RCHAN_TRIG), .FRAME_ERR(FRAME_ERR)
  );

  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    int          kind;
    logic        chan;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] model_l = '0, model_r = '0;
  logic [4:0]  want;
  int          lval_seen = 0, rval_seen = 0, ferr_seen = 0;

  logic        aligned_m = 1'b0, adc_active = 1'b0, cur_lr = 1'b1;
  int          rises = 0;
  logic [15:0] cur_word, adc_word, cap_word, cap_l, cap_r;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
    end
  endtask

  task automatic push_exp(input int due, input int kind, input logic chan, input logic [15:0] data);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.chan = chan;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Pulses due this cycle come from the queue; data outputs must hold the last delivered word.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      want = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due == cyc) begin
          case (exp_q[i].kind)
            0: if (exp_q[i].chan) begin want[1] = 1'b1; model_r = exp_q[i].data; end
               else begin want[0] = 1'b1; model_l = exp_q[i].data; end
            1: want[2] = 1'b1;
            default: if (exp_q[i].chan) want[4] = 1'b1; else want[3] = 1'b1;
          endcase
          exp_q.delete(i);
        end
      end
      check_output("dac_lchan_valid", {31'd0, DAC_LCHAN_VALID}, {31'd0, want[0]});
      check_output("dac_rchan_valid", {31'd0, DAC_RCHAN_VALID}, {31'd0, want[1]});
      check_output("frame_err", {31'd0, FRAME_ERR}, {31'd0, want[2]});
      check_output("adc_lchan_trig", {31'd0, ADC_LCHAN_TRIG}, {31'd0, want[3]});
      check_output("adc_rchan_trig", {31'd0, ADC_RCHAN_TRIG}, {31'd0, want[4]});
      check_output("dac_lchan_data", {16'd0, DAC_LCHAN_DATA}, {16'd0, model_l});
      check_output("dac_rchan_data", {16'd0, DAC_RCHAN_DATA}, {16'd0, model_r});
      lval_seen += int'(DAC_LCHAN_VALID);
      rval_seen += int'(DAC_RCHAN_VALID);
      ferr_seen += int'(FRAME_ERR);
    end else begin
      model_l = '0;
      model_r = '0;
    end
  end

  // One BCLK period: fall (optionally with an LRCK edge), then rise; ADCDAT sampled just before the rise.
  task automatic bclk_period(input logic dac_bit, input logic do_edge, input logic new_lr);
    int k;
    @(negedge CLK);
    AUD_BCLK   = 1'b0;
    AUD_DACDAT = dac_bit;
    if (do_edge) begin
      AUD_DACLRCK = new_lr;
      AUD_ADCLRCK = new_lr;
      if (aligned_m && rises < SB + 1) push_exp(cyc + LAT, 1, new_lr, 16'd0);
      push_exp(cyc + LAT, 2, new_lr, 16'd0);
      aligned_m  = 1'b1;
      adc_active = 1'b1;
      rises      = 0;
      cur_lr     = new_lr;
      adc_word   = new_lr ? ADC_RCHAN_DATA : ADC_LCHAN_DATA;
    end
    repeat (HALF) @(negedge CLK);
    k = rises + 1;
    if (!adc_active) begin
      check_output("adcdat_idle", {31'd0, AUD_ADCDAT}, 32'd0);
    end else if (k >= 2 && k <= SB + 1) begin
      check_output("adcdat_bit", {31'd0, AUD_ADCDAT}, {31'd0, adc_word[SB+1-k]});
      cap_word[SB+1-k] = AUD_ADCDAT;
      if (k == SB + 1) begin
        if (cur_lr) cap_r = cap_word;
        else        cap_l = cap_word;
      end
    end else if (k > SB + 1) begin
      check_output("adcdat_pad", {31'd0, AUD_ADCDAT}, 32'd0);
    end
    AUD_BCLK = 1'b1;
    rises    = k;
    if (aligned_m && rises == SB + 1) push_exp(cyc + LAT, 0, cur_lr, cur_word);
    repeat (HALF - 1) @(negedge CLK);
  endtask

  task automatic apply_stimulus(input logic lr, input logic [15:0] word, input int nbits,
                                input logic [15:0] adc_l, input logic [15:0] adc_r);
    ADC_LCHAN_DATA = adc_l;
    ADC_RCHAN_DATA = adc_r;
    cur_word       = word;
    for (int j = 1; j <= nbits; j++) begin
      logic b;
      b = (j >= 2 && j <= SB + 1) ? word[SB+1-j] : 1'($urandom_range(0, 1));
      bclk_period(b, j == 1, lr);
    end
  endtask

  task automatic run_bits(input int n);
    for (int j = 0; j < n; j++) bclk_period(1'($urandom_range(0, 1)), 1'b0, cur_lr);
  endtask

  initial begin
    int l0, r0, f0, nb;
    logic lr;
    RESET_N        = 1'b0;
    AUD_BCLK       = 1'b0;
    AUD_DACLRCK    = 1'b1;
    AUD_ADCLRCK    = 1'b1;
    AUD_DACDAT     = 1'b0;
    ADC_LCHAN_DATA = '0;
    ADC_RCHAN_DATA = '0;
    repeat (5) @(negedge CLK);
    check_output("reset_adcdat", {31'd0, AUD_ADCDAT}, 32'd0);
    check_output("reset_dac_l", {16'd0, DAC_LCHAN_DATA}, 32'd0);
    check_output("reset_dac_r", {16'd0, DAC_RCHAN_DATA}, 32'd0);
    check_output("reset_pulses", {27'd0, DAC_LCHAN_VALID, DAC_RCHAN_VALID, ADC_LCHAN_TRIG,
                                  ADC_RCHAN_TRIG, FRAME_ERR}, 32'd0);
    RESET_N = 1'b1;

    // Power-up with LRCK high mid-slot: nothing may be reported before the first edge.
    run_bits(12);
    check_output("powerup_no_pulses", lval_seen + rval_seen + ferr_seen, 32'd0);

    apply_stimulus(1'b0, 16'hA55A, 32, 16'h8001, 16'h7FFE);
    apply_stimulus(1'b1, 16'h1234, 32, 16'h8001, 16'h7FFE);
    check_output("frame_l_data", {16'd0, DAC_LCHAN_DATA}, 32'h0000A55A);
    check_output("frame_r_data", {16'd0, DAC_RCHAN_DATA}, 32'h00001234);
    check_output("frame_valid_counts", {lval_seen[15:0], rval_seen[15:0]}, 32'h00010001);
    check_output("frame_no_err", ferr_seen, 32'd0);
    check_output("adc_cap_l", {16'd0, cap_l}, 32'h00008001);
    check_output("adc_cap_r", {16'd0, cap_r}, 32'h00007FFE);

    f0 = ferr_seen;
    apply_stimulus(1'b0, 16'h1111, 10, 16'h0F00, 16'h00F0);
    apply_stimulus(1'b1, 16'hBEEF, 32, 16'h0F00, 16'h00F0);
    check_output("short_ferr_once", ferr_seen - f0, 32'd1);
    check_output("short_l_kept", {16'd0, DAC_LCHAN_DATA}, 32'h0000A55A);
    check_output("short_r_beef", {16'd0, DAC_RCHAN_DATA}, 32'h0000BEEF);

    l0 = lval_seen; r0 = rval_seen; f0 = ferr_seen;
    apply_stimulus(1'b0, 16'hFFFF, 17, 16'h1357, 16'h2468);
    apply_stimulus(1'b1, 16'h0000, 17, 16'h1357, 16'h2468);
    check_output("min_slot_l", {16'd0, DAC_LCHAN_DATA}, 32'h0000FFFF);
    check_output("min_slot_r", {16'd0, DAC_RCHAN_DATA}, 32'h00000000);
    check_output("min_slot_valids", (lval_seen - l0) + (rval_seen - r0), 32'd2);
    apply_stimulus(1'b0, 16'h3C3C, 32, 16'h1357, 16'h2468);
    check_output("min_slot_no_err", ferr_seen - f0, 32'd0);

    lr = 1'b1;
    for (int s = 0; s < 30; s++) begin
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 16) : $urandom_range(17, 32);
      apply_stimulus(lr, 16'($urandom), nb, 16'($urandom), 16'($urandom));
      lr = ~lr;
    end
    if (lr) apply_stimulus(1'b1, 16'($urandom), 24, 16'($urandom), 16'($urandom));

    apply_stimulus(1'b0, 16'h5555, 32, 16'hAAAA, 16'h5555);
    apply_stimulus(1'b1, 16'hC3C3, 8, 16'hAAAA, 16'h5555);
    #3 RESET_N = 1'b0;
    exp_q.delete();
    aligned_m  = 1'b0;
    adc_active = 1'b0;
    rises      = 0;
    #1;
    check_output("midreset_dac_l", {16'd0, DAC_LCHAN_DATA}, 32'd0);
    check_output("midreset_dac_r", {16'd0, DAC_RCHAN_DATA}, 32'd0);
    check_output("midreset_adcdat", {31'd0, AUD_ADCDAT}, 32'd0);
    repeat (4) @(negedge CLK);
    RESET_N = 1'b1;
    l0 = lval_seen; r0 = rval_seen; f0 = ferr_seen;
    run_bits(20);
    check_output("truncated_no_valid", (lval_seen - l0) + (rval_seen - r0), 32'd0);
    apply_stimulus(1'b0, 16'h0F0F, 32, 16'h0001, 16'h8000);
    apply_stimulus(1'b1, 16'hF0F0, 32, 16'h0001, 16'h8000);
    check_output("post_reset_l", {16'd0, DAC_LCHAN_DATA}, 32'h00000F0F);
    check_output("post_reset_r", {16'd0, DAC_RCHAN_DATA}, 32'h0000F0F0);
    check_output("post_reset_no_err", ferr_seen - f0, 32'd0);

    repeat (10) @(negedge CLK);
    check_output("pending_events", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
